// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  // Master id: 0 = m0, 1 = m1.
  typedef logic mid_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/rr_pick2.sv
// Two-way arbiter: on contention grants the master that was not served last.
// Tying last to master 1 turns it into fixed priority favouring m0.
`timescale 1ns/1ps
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mid_t       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last == 1'b1) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port data memory: gnt at N, access at N+1, rvalid at N+2.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with m0 winning.
`timescale 1ns/1ps
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_err,
  output logic          m1_err,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD
);

  arb_state_e    state_q, state_d;
  mid_t          id_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  mid_t       last;
  logic [1:0] pick;
  logic       accept;
  logic       aligned;
  logic       resp;

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (last),
    .gnt  (pick)
  );

  // Requests are only taken outside ACCESS, so one access is in flight at most.
  assign accept  = !rst && (state_q != ACCESS) && (pick != 2'b00);
  assign m0_gnt  = accept && pick[0];
  assign m1_gnt  = accept && pick[1];
  assign aligned = (addr_q[1:0] & ALIGN_MASK) == 2'b00;

`ifdef MEM_ARB_RR_EN
  mid_t last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= pick[1];
    end
  end

  assign last = last_q;
`else
  assign last = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q    <= pick[1];
        we_q    <= pick[1] ? m1_we    : m0_we;
        addr_q  <= pick[1] ? m1_addr  : m0_addr;
        wdata_q <= pick[1] ? m1_wdata : m0_wdata;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (!we_q && aligned) ? mem_RD : '0;
        err_q   <= !aligned;
      end
    end
  end

  // Address and write data simply follow the latched request, so they hold outside ACCESS.
  assign mem_A  = addr_q;
  assign mem_WD = wdata_q;
  assign mem_WE = (state_q == ACCESS) && we_q && aligned;

  assign resp      = (state_q == RESP);
  assign m0_rvalid = resp && (id_q == 1'b0);
  assign m1_rvalid = resp && (id_q == 1'b1);
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 16-word behavioural data memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_WE) mem[mem_A[5:2]] <= mem_WD;
  assign mem_RD = mem[mem_A[5:2]];

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_we     (m0_we),
    .m1_we     (m1_we),
    .m0_addr   (m0_addr),
    .m1_addr   (m1_addr),
    .m0_wdata  (m0_wdata),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .m0_err    (m0_err),
    .m1_err    (m1_err),
    .mem_A     (mem_A),
    .mem_WD    (mem_WD),
    .mem_WE    (mem_WE),
    .mem_RD    (mem_RD)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cyc     = 0;
  int          we_cnt  = 0;
  int          both_cnt = 0;
  logic [31:0] g0[$], g1[$], rv0[$], rv1[$], rd0[$], rd1[$], er0[$], er1[$], order[$];
  logic [31:0] exp_order [4];

  // Event log, sampled mid-cycle; inputs change just after posedge.
  always @(negedge clk) begin
    if (m0_gnt) begin g0.push_back(cyc); order.push_back(32'd0); end
    if (m1_gnt) begin g1.push_back(cyc); order.push_back(32'd1); end
    if (m0_gnt && m1_gnt) both_cnt++;
    if (m0_rvalid) begin rv0.push_back(cyc); rd0.push_back(m0_rdata); er0.push_back({31'd0, m0_err}); end
    if (m1_rvalid) begin rv1.push_back(cyc); rd1.push_back(m1_rdata); er1.push_back({31'd0, m1_err}); end
    if (mem_WE) we_cnt++;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_logs();
    g0.delete(); g1.delete(); rv0.delete(); rv1.delete();
    rd0.delete(); rd1.delete(); er0.delete(); er1.delete(); order.delete();
    we_cnt = 0;
    both_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_req = 1'b0;
    m1_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Raise req with payload, hold until gnt, drop it in the following cycle.
  task automatic access(input bit m, input bit we, input logic [31:0] addr,
                        input logic [31:0] data);
    bit got;
    got = 1'b0;
    if (!m) begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = data; end
    else    begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = data; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      got = m ? m1_gnt : m0_gnt;
      if (got) break;
    end
    check("gnt_wait", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (!m) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    rst = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = 32'd0; m1_addr = 32'd0;
    m0_wdata = 32'd0; m1_wdata = 32'd0;

    // Reset state, with both requests raised to show gnt is suppressed.
    #7;
    check("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    check("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    check("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    check("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_WE}, 32'd0);
    check("rst_mem_a", mem_A, 32'd0);
    check("rst_mem_wd", mem_WD, 32'd0);
    check("rst_m0_err", {31'd0, m0_err}, 32'd0);
    check("rst_rdata", m1_rdata, 32'd0);
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    rst = 1'b0;
    wait_cycles(1);

    // Write then read back 0x10 from m0.
    clear_logs();
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 32'h10, 32'h0);
    wait_cycles(4);
    check("wr_gnt_cnt", g0.size(), 32'd2);
    check("wr_rv_lat", qget(rv0, 0), qget(g0, 0) + 32'd2);
    check("wr_rdata", qget(rd0, 0), 32'd0);
    check("wr_err", qget(er0, 0), 32'd0);
    check("wr_we_cycles", we_cnt, 32'd1);
    check("rd_gnt_b2b", qget(g0, 1), qget(g0, 0) + 32'd2);
    check("rd_rv_lat", qget(rv0, 1), qget(g0, 1) + 32'd2);
    check("rd_rdata", qget(rd0, 1), 32'hDEAD_BEEF);
    check("rd_err", qget(er0, 1), 32'd0);
    check("mem_w4", mem[4], 32'hDEAD_BEEF);

    // Contention: both masters hold req for 4 accesses.
`ifdef MEM_ARB_RR_EN
    exp_order[0] = 32'd0; exp_order[1] = 32'd1; exp_order[2] = 32'd0; exp_order[3] = 32'd1;
`else
    exp_order[0] = 32'd0; exp_order[1] = 32'd0; exp_order[2] = 32'd0; exp_order[3] = 32'd0;
`endif
    do_reset();
    clear_logs();
    m0_we = 1'b0; m0_addr = 32'h4; m1_we = 1'b0; m1_addr = 32'h8;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 30 && order.size() < 4; i++) begin
      @(posedge clk); #1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    wait_cycles(4);
    check("arb_cnt", order.size(), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("arb_order%0d", i), qget(order, i), exp_order[i]);
    check("arb_one_hot", both_cnt, 32'd0);
    check("arb_rv_cnt", rv0.size() + rv1.size(), 32'd4);

    // Misaligned m1 write must not touch memory.
    clear_logs();
    access(1'b1, 1'b1, 32'h13, 32'h55AA_55AA);
    wait_cycles(3);
    check("mis_we_cycles", we_cnt, 32'd0);
    check("mis_rv_cnt", rv1.size(), 32'd1);
    check("mis_rv_lat", qget(rv1, 0), qget(g1, 0) + 32'd2);
    check("mis_err", qget(er1, 0), 32'd1);
    check("mis_rdata", qget(rd1, 0), 32'd0);
    check("mis_mem_w4", mem[4], 32'hDEAD_BEEF);

    // Back-to-back m0 reads.
    mem[0] <= 32'h1111_1111;
    mem[1] <= 32'h2222_2222;
    mem[2] <= 32'h3333_3333;
    wait_cycles(1);
    clear_logs();
    access(1'b0, 1'b0, 32'h0, 32'h0);
    access(1'b0, 1'b0, 32'h4, 32'h0);
    access(1'b0, 1'b0, 32'h8, 32'h0);
    wait_cycles(4);
    check("b2b_g1", qget(g0, 1), qget(g0, 0) + 32'd2);
    check("b2b_g2", qget(g0, 2), qget(g0, 0) + 32'd4);
    check("b2b_rv0", qget(rv0, 0), qget(g0, 0) + 32'd2);
    check("b2b_rv1", qget(rv0, 1), qget(g0, 0) + 32'd4);
    check("b2b_rv2", qget(rv0, 2), qget(g0, 0) + 32'd6);
    check("b2b_rd0", qget(rd0, 0), 32'h1111_1111);
    check("b2b_rd1", qget(rd0, 1), 32'h2222_2222);
    check("b2b_rd2", qget(rd0, 2), 32'h3333_3333);

    // Reset during the ACCESS cycle of a write.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (m0_gnt) break;
    end
    check("rst_mid_gnt", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    check("rst_mid_we_before", {31'd0, mem_WE}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_we_drop", {31'd0, mem_WE}, 32'd0);
    m0_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    wait_cycles(3);
    check("rst_mid_no_rv", rv0.size() + rv1.size(), 32'd0);
    check("rst_mid_mem", mem[8], 32'd0);
    m0_we = 1'b0; m0_addr = 32'h0; m1_we = 1'b0; m1_addr = 32'h4;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 10 && order.size() == 0; i++) begin
      @(posedge clk); #1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    wait_cycles(3);
    check("post_rst_first", qget(order, 0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
